// File: rtl/alu_pkg.sv
// Shared definitions for the serial logic unit: opcodes and FSM encoding.
package alu_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND = 2'b00;
  localparam op_t OP_OR  = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_NOR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-bit bitwise evaluator shared by every serial step.
module logic_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial_logic.sv
// Bit-serial AND/OR/XOR/NOR unit: one CHUNK per clock, LSB chunk first,
// result reassembled by shifting in from the MSB side. CHUNK must divide WIDTH.
module alu_serial_logic
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NCHUNK - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_t              r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_nz;

  logic [CHUNK-1:0] w_y;
  logic [WIDTH-1:0] w_res_shift;

  logic_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a  (r_a[CHUNK-1:0]),
    .b  (r_b[CHUNK-1:0]),
    .op (r_op),
    .y  (w_y)
  );

  // A single-chunk build has no older result bits to carry along.
  generate
    if (CHUNK == WIDTH) begin : g_full
      assign w_res_shift = w_y;
    end else begin : g_part
      assign w_res_shift = {w_y, r_res[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_AND;
      r_cnt   <= '0;
      r_res   <= '0;
      r_nz    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= CNT_LOAD;
            r_res   <= '0;
            r_nz    <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res <= w_res_shift;
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          r_nz  <= r_nz | (|w_y);
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gating with reset keeps in_ready low for the whole reset pulse.
  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign out_valid = (r_state == ST_DONE);
  assign out       = r_res;
  assign zero      = (r_state == ST_DONE) && !r_nz;

endmodule

// File: tb/tb_alu_serial_logic.sv
// Directed bench for alu_serial_logic: default 1-bit build plus CHUNK=8 and CHUNK=32 builds.
module tb_alu_serial_logic;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [31:0] a, b, out;
  logic [1:0]  op;

  logic        x_valid, x_ready;
  logic [31:0] x_a, x_b;
  logic [1:0]  x_op;
  logic        o8_in_ready, o8_valid, o8_zero;
  logic [31:0] o8_out;
  logic        o32_in_ready, o32_valid, o32_zero;
  logic [31:0] o32_out;

  alu_serial_logic #(.WIDTH(32), .CHUNK(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero)
  );

  alu_serial_logic #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(o8_in_ready),
    .a(x_a), .b(x_b), .op(x_op), .out_valid(o8_valid), .out_ready(x_ready),
    .out(o8_out), .zero(o8_zero)
  );

  alu_serial_logic #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(o32_in_ready),
    .a(x_a), .b(x_b), .op(x_op), .out_valid(o32_valid), .out_ready(x_ready),
    .out(o32_out), .zero(o32_zero)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept log for the default build, used for throughput measurement.
  int cyc = 0;
  int acc_time[$];
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_time.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the default build; pulse_at >= 1 injects a stray in_valid during RUN.
  task automatic run_op(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [1:0] op_v, input logic [31:0] exp, input logic exp_zero,
                        input int hold, input int pulse_at);
    int lat;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    a = a_v; b = b_v; op = op_v; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~a_v; b = ~b_v; op = ~op_v;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
      in_valid = (lat == pulse_at);
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd32);
    check({tag, "_out"}, out, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    check({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) step();
      check({tag, "_hold_out"}, out, exp);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    $display("txn %s a=%h b=%h op=%0d out=%h zero=%0d lat=%0d", tag, a_v, b_v, op_v, exp, exp_zero, lat);
  endtask

  initial begin
    int k, n0, t8, t32, seen;
    logic [31:0] r8, r32;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 2'b00;
    x_valid = 1'b0; x_ready = 1'b0; x_a = '0; x_b = '0; x_op = 2'b00;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'h0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst8_in_ready", 32'(o8_in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    $display("txn reset released");

    run_op("and", 32'hFFFF0000, 32'h0F0F0F0F, 2'b00, 32'h0F0F0000, 1'b0, 0, -1);

    // Back-to-back XOR then NOR with out_ready tied high; op changes after accept.
    out_ready = 1'b1;
    a = 32'hAAAAAAAA; b = 32'h55555555; op = 2'b10; in_valid = 1'b1;
    n0 = acc_time.size();
    k = 0;
    while (acc_time.size() == n0 && k < 50) begin step(); k++; end
    op = 2'b11;
    k = 0;
    while (!out_valid && k < 100) begin step(); k++; end
    check("xor_lat", 32'(k), 32'd32);
    check("xor_out", out, 32'hFFFFFFFF);
    check("xor_zero", 32'(zero), 32'd0);
    $display("txn xor a=aaaaaaaa b=55555555 out=%h", out);
    k = 0;
    while (acc_time.size() < n0 + 2 && k < 50) begin step(); k++; end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(acc_time.size() - n0), 32'd2);
    if (acc_time.size() >= n0 + 2)
      check("b2b_spacing", 32'(acc_time[n0+1] - acc_time[n0]), 32'd34);
    k = 0;
    while (!out_valid && k < 100) begin step(); k++; end
    check("nor_lat", 32'(k), 32'd32);
    check("nor_out", out, 32'h00000000);
    check("nor_zero", 32'(zero), 32'd1);
    $display("txn nor a=aaaaaaaa b=55555555 out=%h zero=%0d", out, zero);
    step();
    out_ready = 1'b0;
    check("b2b_idle_rdy", 32'(in_ready), 32'd1);

    run_op("or_bp", 32'h12345678, 32'h00000000, 2'b01, 32'h12345678, 1'b0, 10, -1);
    run_op("busy", 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 32'hF000F000, 1'b0, 0, 5);

    // Reset during RUN abandons the operation.
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_out", out, 32'h0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("mrst_rel_rdy", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen = 1;
    end
    check("mrst_no_valid", 32'(seen), 32'd0);
    $display("txn reset mid-run abandoned");
    run_op("and_after_rst", 32'h13579BDF, 32'hFFFF0000, 2'b00, 32'h13570000, 1'b0, 0, -1);

    // CHUNK=8 and CHUNK=32 builds fed the same operands.
    x_ready = 1'b1;
    check("x_ready8", 32'(o8_in_ready), 32'd1);
    x_a = 32'hDEADBEEF; x_b = 32'hFFFFFFFF; x_op = 2'b00; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    t8 = -1; t32 = -1; r8 = '0; r32 = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (o8_valid && t8 < 0) begin t8 = i; r8 = o8_out; end
      if (o32_valid && t32 < 0) begin t32 = i; r32 = o32_out; end
    end
    check("c8_lat", 32'(t8), 32'd4);
    check("c8_out", r8, 32'hDEADBEEF);
    check("c32_lat", 32'(t32), 32'd1);
    check("c32_out", r32, 32'hDEADBEEF);
    $display("txn chunk8 out=%h lat=%0d, chunk32 out=%h lat=%0d", r8, t8, r32, t32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_logic.md
# alu_serial_logic

Multi-cycle, bit-serial logic unit for the sequential processor: accepts two 32-bit operands plus an opcode over a valid/ready handshake. It evaluates AND/OR/XOR/NOR one chunk per clock, least-significant chunk first, and returns the reassembled 32-bit result over a second valid/ready handshake. It is the serial counterpart to the parallel 32-bit bitwise gate arrays, used where area matters more than latency.

## Interface
- WIDTH, 32, operand/result width
- CHUNK, 1, bits processed per cycle; must divide WIDTH exactly
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- out  output  WIDTH  result
- zero  output  1  result is all zeros; qualified by out_valid

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a, b and op into shift registers; load counter with WIDTH/CHUNK−1; clear the result register and zero accumulator; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle: apply op to the low CHUNK bits of A/B. Shift the outcome into the result register from the MSB side. Shift A/B right by CHUNK. OR the outcome bits into a "nonzero" accumulator.
  - When the counter is 0 while in RUN, go to DONE; otherwise decrement the counter.
- DONE:
  - out_valid = 1.
  - out holds the full result, with chunk i at bits [i*CHUNK +: CHUNK].
  - zero = ~nonzero.
  - On out_ready, go to IDLE.
  - out and zero hold stable while out_valid & ~out_ready.
- op is latched at accept; changes on the op input after accept have no effect.
- in_valid while busy is ignored. No operands are queued; the upstream must hold them.

## Timing
- Reset (synchronous, takes effect at the edge where reset = 1):
  - state = IDLE, counter = 0, out = 0, zero = 0, out_valid = 0.
  - in_ready = 0 while reset is high; 1 in the first cycle after reset deasserts.
- Reset mid-operation (RUN or DONE): the operation is abandoned, no out_valid pulse occurs, and the state returns to IDLE.
- Latency: accept at edge E0; chunks processed at edges E1..E(WIDTH/CHUNK); out_valid is high in the cycle after edge E(WIDTH/CHUNK).
  - Defaults: 32 edges from accept to out_valid.
  - CHUNK=8: 4 edges.
- Throughput: with out_ready tied high, one operation per WIDTH/CHUNK+2 cycles (accept, RUN, DONE→IDLE). There is no same-cycle re-accept in DONE.
- Handshake: in_ready and out_valid never assert together, so in_ready is never high in DONE.
- Boundary: CHUNK = WIDTH is legal. RUN then lasts one cycle, and the counter loads 0.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - state encoding (IDLE=0, RUN=1, DONE=2).
- One sub-module: logic_slice. It is a combinational CHUNK-bit op evaluator (inputs a, b, op; output y), instantiated once in the datapath.
- Counter width is $clog2(WIDTH/CHUNK), minimum 1.

## Test plan
- Reset release, then a=32'hFFFF0000, b=32'h0F0F0F0F, op=AND → out_valid 32 cycles after the accept edge, out=32'h0F0F0000, zero=0.
- a=32'hAAAAAAAA, b=32'h55555555, op=XOR, then op=NOR, back-to-back with out_ready=1 → XOR gives 32'hFFFFFFFF, NOR gives 32'h00000000 with zero=1. The second accept occurs no earlier than 34 cycles after the first.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with a=32'h12345678, b=32'h0, op=OR → out holds 32'h12345678 and in_ready stays 0 until out_ready is seen; in_ready=1 the following cycle.
- Busy protection: pulse in_valid with different operands during RUN → ignored; the result matches the original operands.
- Reset asserted mid-RUN (cycle 10) → out_valid never asserts, out=0, in_ready=1 one cycle after reset drops; a new AND completes correctly.
- CHUNK=8 build: a=32'hDEADBEEF, b=32'hFFFFFFFF, op=AND → out=32'hDEADBEEF, 4 edges after accept.
